// File: rtl/nes_pad_poller.sv
// NES joypad poller: latches the pad's CD4021, clocks out 8 bits,
// and publishes one masked button byte per poll frame.
module nes_pad_poller #(
    parameter int LATCH_CYC     = 22,
    parameter int HALF_CYC      = 11,
    parameter int POLL_CYC      = 29830,
    parameter bit MASK_OPPOSING = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pad_data_n,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_LOW   = 3'd2;
    localparam logic [2:0] S_HIGH  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_WAIT  = 3'd5;

    localparam int PW   = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam int CMAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYC - 1);
    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYC - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYC - 1);

    logic [2:0]    state;
    logic [2:0]    state_nx;
    logic [CW-1:0] cyc_cnt;
    logic [PW-1:0] poll_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic [7:0]    frame;
    logic [7:0]    masked;
    logic [1:0]    sync;
    logic          sample;
    logic          latch_end;
    logic          half_end;
    logic          poll_end;
    logic          last_bit_end;

    assign sample       = ~sync[1];
    assign latch_end    = (cyc_cnt == LATCH_LAST);
    assign half_end     = (cyc_cnt == HALF_LAST);
    assign poll_end     = (poll_cnt >= POLL_LAST);
    assign last_bit_end = (state == S_LOW) && half_end && (bit_idx == 3'd7);

    // Two-flop synchronizer for the asynchronous pad data line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], pad_data_n};
        end
    end

    // Next-state decode for the poll sequence
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (enable) state_nx = S_LATCH;
            end
            S_LATCH: begin
                if (latch_end) state_nx = S_LOW;
            end
            S_LOW: begin
                if (half_end) begin
                    state_nx = (bit_idx == 3'd7) ? S_DONE : S_HIGH;
                end
            end
            S_HIGH: begin
                if (half_end) state_nx = S_LOW;
            end
            S_DONE: begin
                state_nx = (enable && poll_end) ? S_LATCH : S_WAIT;
            end
            S_WAIT: begin
                if (poll_end) state_nx = enable ? S_LATCH : S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Final byte: the 8th bit arrives in the same cycle it is published
    always_comb begin
        frame    = shift;
        frame[7] = sample;
        masked   = frame;
        if (MASK_OPPOSING) begin
            if (frame[4] && frame[5]) masked[5:4] = 2'b00;
            if (frame[6] && frame[7]) masked[7:6] = 2'b00;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Phase timer: restarts on every state change, runs in timed phases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else if (state_nx != state) begin
            cyc_cnt <= '0;
        end else if (state == S_LATCH || state == S_LOW || state == S_HIGH) begin
            cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

    // Poll period counter, zero on the LATCH entry cycle, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            poll_cnt <= '0;
        end else if (state_nx == S_LATCH && state != S_LATCH) begin
            poll_cnt <= '0;
        end else if (state != S_IDLE && poll_cnt != '1) begin
            poll_cnt <= poll_cnt + 1'b1;
        end
    end

    // Bit index advances at the end of each pad_clk high phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= 3'd0;
        end else if (state == S_LATCH) begin
            bit_idx <= 3'd0;
        end else if (state == S_HIGH && half_end) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    // Capture each data bit on the last cycle of its low phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= 8'h00;
        end else if (state == S_LOW && half_end) begin
            shift[bit_idx] <= sample;
        end
    end

    // Publish the masked byte together with the valid pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buttons <= 8'h00;
        end else if (last_bit_end) begin
            buttons <= masked;
        end
    end

    // Registered, glitch-free outputs decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            pad_latch <= (state_nx == S_LATCH);
            pad_clk   <= (state_nx == S_HIGH);
            valid     <= (state_nx == S_DONE);
            busy      <= (state_nx == S_LATCH) || (state_nx == S_LOW) ||
                         (state_nx == S_HIGH)  || (state_nx == S_DONE);
        end
    end

endmodule
